// File: rtl/answer_checker.sv
// answer_checker: receiving end of the answer-generator interface.
// Holds the current answer and scores each player guess Mastermind-style.
// A guess is scored in two passes. SCAN walks the positions, one per cycle,
// counting strikes and building per-value histograms for the answer and the
// guess. TALLY then walks the digit values, one per cycle, and sums
// min(histA, histG). That sum is every matching digit, so balls = sum - strikes.
module answer_checker #(
  parameter int DIGITS = 8,
  parameter int DW     = 4,
  parameter int MAXV   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGITS*DW-1:0] answer_in,
  input  logic                 answer_we,
  input  logic [DIGITS*DW-1:0] guess,
  input  logic                 guess_valid,
  output logic                 busy,
  output logic                 answer_loaded,
  output logic                 result_valid,
  output logic [3:0]           strikes,
  output logic [3:0]           balls,
  output logic                 guess_invalid,
  output logic                 solved,
  output logic [7:0]           attempts
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HW = $clog2(MAXV + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [HW-1:0] V_LAST     = HW'(MAXV);
  localparam logic [3:0]    STRIKE_ALL = 4'(DIGITS);
  localparam logic [DW-1:0] DIG_MAX    = DW'(MAXV);

  typedef enum logic [1:0] {S_NOLOAD, S_READY, S_SCAN, S_TALLY} state_t;

  state_t                 state_q, state_d;
  logic [DIGITS*DW-1:0]   answer_q, answer_d;
  logic [DIGITS*DW-1:0]   guess_q, guess_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [HW-1:0]          v_q, v_d;
  logic [3:0]             hist_a_q [MAXV+1];
  logic [3:0]             hist_a_d [MAXV+1];
  logic [3:0]             hist_g_q [MAXV+1];
  logic [3:0]             hist_g_d [MAXV+1];
  logic [3:0]             strike_cnt_q, strike_cnt_d;
  logic [3:0]             total_q, total_d;
  logic                   invalid_q, invalid_d;
  logic                   busy_q, busy_d;
  logic                   loaded_q, loaded_d;
  logic                   result_valid_q, result_valid_d;
  logic [3:0]             strikes_q, strikes_d;
  logic [3:0]             balls_q, balls_d;
  logic                   guess_invalid_q, guess_invalid_d;
  logic                   solved_q, solved_d;
  logic [7:0]             attempts_q, attempts_d;

  // Working values for the position and value walks.
  logic [DW-1:0] a_dig, g_dig;
  logic          a_legal, g_legal;
  logic [3:0]    ha, hg, hmin, tot;

  // Next-state logic: answer capture has priority over everything else.
  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    answer_d        = answer_q;
    guess_d         = guess_q;
    idx_d           = idx_q;
    v_d             = v_q;
    hist_a_d        = hist_a_q;
    hist_g_d        = hist_g_q;
    strike_cnt_d    = strike_cnt_q;
    total_d         = total_q;
    invalid_d       = invalid_q;
    loaded_d        = loaded_q;
    result_valid_d  = 1'b0;
    strikes_d       = strikes_q;
    balls_d         = balls_q;
    guess_invalid_d = guess_invalid_q;
    solved_d        = solved_q;
    attempts_d      = attempts_q;

    a_dig   = answer_q[DW*idx_q +: DW];
    g_dig   = guess_q[DW*idx_q +: DW];
    a_legal = (a_dig != '0) && (a_dig <= DIG_MAX);
    g_legal = (g_dig != '0) && (g_dig <= DIG_MAX);
    ha      = hist_a_q[v_q];
    hg      = hist_g_q[v_q];
    hmin    = (ha < hg) ? ha : hg;
    tot     = total_q + hmin;

    if (answer_we) begin
      // A new answer aborts any scoring in flight and drops a same-cycle guess.
      answer_d   = answer_in;
      loaded_d   = 1'b1;
      solved_d   = 1'b0;
      attempts_d = 8'd0;
      state_d    = S_READY;
    end else begin
      unique case (state_q)
        S_NOLOAD: ;
        S_READY: begin
          if (guess_valid) begin
            guess_d      = guess;
            strike_cnt_d = 4'd0;
            total_d      = 4'd0;
            invalid_d    = 1'b0;
            hist_a_d     = '{default: '0};
            hist_g_d     = '{default: '0};
            idx_d        = '0;
            state_d      = S_SCAN;
          end
        end
        S_SCAN: begin
          if (a_legal) hist_a_d[HW'(a_dig)] = hist_a_q[HW'(a_dig)] + 4'd1;
          if (g_legal) hist_g_d[HW'(g_dig)] = hist_g_q[HW'(g_dig)] + 4'd1;
          else         invalid_d = 1'b1;
          if (g_legal && (a_dig == g_dig)) strike_cnt_d = strike_cnt_q + 4'd1;
          if (idx_q == IDX_LAST) begin
            v_d     = HW'(1);
            state_d = S_TALLY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_TALLY: begin
          total_d = tot;
          if (v_q == V_LAST) begin
            strikes_d       = strike_cnt_q;
            balls_d         = tot - strike_cnt_q;
            guess_invalid_d = invalid_q;
            result_valid_d  = 1'b1;
            if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
            solved_d        = solved_q | (strike_cnt_q == STRIKE_ALL);
            state_d         = S_READY;
          end else begin
            v_d = v_q + 1'b1;
          end
        end
        default: state_d = S_NOLOAD;
      endcase
    end

    busy_d = (state_d == S_SCAN) || (state_d == S_TALLY);
  end

  // State and output registers.
  // NOTE: the histograms are a handful of flops, so they are reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_NOLOAD;
      answer_q        <= '0;
      guess_q         <= '0;
      idx_q           <= '0;
      v_q             <= '0;
      hist_a_q        <= '{default: '0};
      hist_g_q        <= '{default: '0};
      strike_cnt_q    <= '0;
      total_q         <= '0;
      invalid_q       <= 1'b0;
      busy_q          <= 1'b0;
      loaded_q        <= 1'b0;
      result_valid_q  <= 1'b0;
      strikes_q       <= '0;
      balls_q         <= '0;
      guess_invalid_q <= 1'b0;
      solved_q        <= 1'b0;
      attempts_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q         <= state_d;
      answer_q        <= answer_d;
      guess_q         <= guess_d;
      idx_q           <= idx_d;
      v_q             <= v_d;
      hist_a_q        <= hist_a_d;
      hist_g_q        <= hist_g_d;
      strike_cnt_q    <= strike_cnt_d;
      total_q         <= total_d;
      invalid_q       <= invalid_d;
      busy_q          <= busy_d;
      loaded_q        <= loaded_d;
      result_valid_q  <= result_valid_d;
      strikes_q       <= strikes_d;
      balls_q         <= balls_d;
      guess_invalid_q <= guess_invalid_d;
      solved_q        <= solved_d;
      attempts_q      <= attempts_d;
    end
  end

  assign busy          = busy_q;
  assign answer_loaded = loaded_q;
  assign result_valid  = result_valid_q;
  assign strikes       = strikes_q;
  assign balls         = balls_q;
  assign guess_invalid = guess_invalid_q;
  assign solved        = solved_q;
  assign attempts      = attempts_q;

endmodule

// File: tb/tb_answer_checker.sv
// Bench for answer_checker: directed game scenarios plus randomized guesses,
// scored against a counting model of the Mastermind rules.
module tb_answer_checker;

  localparam int DIGITS = 8;
  localparam int DW     = 4;
  localparam int MAXV   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] answer_in;
  logic        answer_we;
  logic [31:0] guess;
  logic        guess_valid;
  logic        busy, answer_loaded, result_valid, guess_invalid, solved;
  logic [3:0]  strikes, balls;
  logic [7:0]  attempts;

  answer_checker #(.DIGITS(DIGITS), .DW(DW), .MAXV(MAXV)) dut (
    .clk(clk), .rst_n(rst_n),
    .answer_in(answer_in), .answer_we(answer_we),
    .guess(guess), .guess_valid(guess_valid),
    .busy(busy), .answer_loaded(answer_loaded), .result_valid(result_valid),
    .strikes(strikes), .balls(balls), .guess_invalid(guess_invalid),
    .solved(solved), .attempts(attempts)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference game state.
  logic [31:0] ans_m;
  int          attempts_m;
  bit          solved_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit is_legal(input int d);
    return (d >= 1) && (d <= MAXV);
  endfunction

  // Mastermind score from the rules: count matching values, subtract exact hits.
  function automatic void ref_score(input logic [31:0] a, input logic [31:0] g,
                                    output int s, output int b, output bit inv);
    int ca[16];
    int cg[16];
    int tot;
    s = 0; b = 0; inv = 0; tot = 0;
    for (int i = 0; i < 16; i++) begin ca[i] = 0; cg[i] = 0; end
    for (int i = 0; i < DIGITS; i++) begin
      int ad, gd;
      ad = int'(a[DW*i +: DW]);
      gd = int'(g[DW*i +: DW]);
      if (is_legal(ad)) ca[ad]++;
      if (is_legal(gd)) cg[gd]++;
      else inv = 1;
      if (is_legal(gd) && ad == gd) s++;
    end
    for (int v = 1; v <= MAXV; v++) tot += (ca[v] < cg[v]) ? ca[v] : cg[v];
    b = tot - s;
  endfunction

  function automatic logic [31:0] rand_word(input int lo, input int hi);
    logic [31:0] w;
    for (int i = 0; i < DIGITS; i++) w[DW*i +: DW] = 4'($urandom_range(hi, lo));
    return w;
  endfunction

  task automatic load_answer(input logic [31:0] a);
    answer_in = a;
    answer_we = 1'b1;
    tick();
    answer_we = 1'b0;
    ans_m = a; attempts_m = 0; solved_m = 0;
    check("load_loaded", answer_loaded, 1);
    check("load_attempts", attempts, 0);
    check("load_solved", solved, 0);
    check("load_busy", busy, 0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (result_valid) hits++;
    end
    check(tag, hits, 0);
  endtask

  // Score one guess; optionally re-assert guess_valid mid-SCAN, which must be ignored.
  task automatic score_guess(input logic [31:0] g, input bit poke);
    int lat;
    int s, b;
    bit inv;
    guess = g;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    check("busy_scan", busy, 1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (poke && c == 3) begin
        guess = ~g;
        guess_valid = 1'b1;
      end
      tick();
      guess_valid = 1'b0;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, 16);
    ref_score(ans_m, g, s, b, inv);
    if (attempts_m < 255) attempts_m++;
    if (s == DIGITS) solved_m = 1;
    check("strikes", strikes, s);
    check("balls", balls, b);
    check("guess_invalid", guess_invalid, inv);
    check("attempts", attempts, attempts_m);
    check("solved", solved, solved_m);
    tick();
    check("rv_pulse", result_valid, 0);
    check("busy_done", busy, 0);
    if (poke) expect_quiet("poke_ignored", 20);
  endtask

  task automatic directed(input logic [31:0] g, input int es, input int eb, input bit einv);
    score_guess(g, 1'b0);
    check("dir_strikes", strikes, es);
    check("dir_balls", balls, eb);
    check("dir_invalid", guess_invalid, einv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    answer_in = '0; answer_we = 1'b0; guess = '0; guess_valid = 1'b0;
    ans_m = '0; attempts_m = 0; solved_m = 0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_loaded", answer_loaded, 0);
    check("rst_rv", result_valid, 0);
    check("rst_strikes", strikes, 0);
    check("rst_balls", balls, 0);
    check("rst_invalid", guess_invalid, 0);
    check("rst_solved", solved, 0);
    check("rst_attempts", attempts, 0);
    rst_n = 1'b1;
    tick();

    // Guess before any answer is ignored.
    guess = 32'h12345678; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    check("noload_busy", busy, 0);
    expect_quiet("noload_quiet", 20);

    load_answer(32'h12345678);
    directed(32'h12345678, 8, 0, 0);
    check("t1_solved", solved, 1);
    check("t1_attempts", attempts, 1);

    load_answer(32'h12345678);
    directed(32'h87654321, 0, 8, 0);
    check("t2_solved", solved, 0);

    load_answer(32'h11112222);
    directed(32'h12121212, 4, 4, 0);
    load_answer(32'h11111111);
    directed(32'h12345678, 1, 0, 0);
    directed(32'h00000000, 0, 0, 1);

    // Answer write five cycles into SCAN aborts the comparison.
    load_answer(32'h12345678);
    guess = 32'h12345678; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    repeat (5) tick();
    check("abort_busy_before", busy, 1);
    load_answer(32'h23456781);
    expect_quiet("abort_quiet", 20);
    check("abort_attempts", attempts, 0);
    check("abort_busy_after", busy, 0);
    directed(32'h23456781, 8, 0, 0);

    // Same-cycle answer write and guess: guess dropped, new answer taken.
    answer_in = 32'h34567812; answer_we = 1'b1;
    guess = 32'h34567812; guess_valid = 1'b1;
    tick();
    answer_we = 1'b0; guess_valid = 1'b0;
    ans_m = 32'h34567812; attempts_m = 0; solved_m = 0;
    check("same_busy", busy, 0);
    check("same_solved", solved, 0);
    expect_quiet("same_quiet", 20);
    check("same_attempts", attempts, 0);
    directed(32'h34567812, 8, 0, 0);

    // guess_valid during SCAN is not queued.
    score_guess(32'h81234567, 1'b1);

    // Randomized answers and guesses.
    for (int it = 0; it < 60; it++) begin
      logic [31:0] g;
      int mode;
      if ($urandom_range(3, 0) == 0) load_answer(rand_word(1, MAXV));
      mode = int'($urandom_range(3, 0));
      case (mode)
        0: g = ans_m;
        1: g = rand_word(1, MAXV);
        2: g = rand_word(0, 15);
        default: begin
          for (int i = 0; i < DIGITS; i++) begin
            int p;
            p = int'($urandom_range(DIGITS - 1, 0));
            g[DW*i +: DW] = ans_m[DW*p +: DW];
          end
        end
      endcase
      score_guess(g, 1'b0);
    end

    // Attempt counter saturates at 255.
    load_answer(rand_word(1, MAXV));
    for (int it = 0; it < 257; it++) score_guess(rand_word(1, MAXV), 1'b0);
    check("attempts_sat", attempts, 8'hFF);

    // Reset pulse mid-TALLY returns everything to reset values at once.
    guess = rand_word(1, MAXV); guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    repeat (11) tick();
    check("tally_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_loaded", answer_loaded, 0);
    check("mrst_rv", result_valid, 0);
    check("mrst_strikes", strikes, 0);
    check("mrst_balls", balls, 0);
    check("mrst_invalid", guess_invalid, 0);
    check("mrst_solved", solved, 0);
    check("mrst_attempts", attempts, 0);
    #2;
    rst_n = 1'b1;
    tick();
    guess = 32'h12345678; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    check("post_rst_busy", busy, 0);
    expect_quiet("post_rst_quiet", 20);

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
